// File: rtl/ex_mem_if.sv
// ex_mem_if: EX/MEM write-back triple plus madd/msub scratch state between EX and the EX/MEM register.
interface ex_mem_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0]   ex_wd;
   logic                ex_wreg;
   logic [DATA_W-1:0]   ex_wdata;
   logic [2*DATA_W-1:0] hilo_i;
   logic [1:0]          cnt_i;
   logic [ADDR_W-1:0]   mem_wd;
   logic                mem_wreg;
   logic [DATA_W-1:0]   mem_wdata;
   logic [2*DATA_W-1:0] hilo_o;
   logic [1:0]          cnt_o;
   modport master (
      output ex_wd, ex_wreg, ex_wdata, hilo_i, cnt_i,
      input  mem_wd, mem_wreg, mem_wdata, hilo_o, cnt_o
   );
   modport slave (
      input  ex_wd, ex_wreg, ex_wdata, hilo_i, cnt_i,
      output mem_wd, mem_wreg, mem_wdata, hilo_o, cnt_o
   );
endinterface

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with stall/bubble/flush handling and madd/msub scratch feedback.
// Optional EX_MEM_BUBBLE_CNT_EN adds a 32-bit bubble_cnt output counting bubble cycles.
module ex_mem_reg #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int STALL_W = 6,
   parameter int EX_IDX  = 3,
   parameter int MEM_IDX = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   ex_mem_if.slave            bus
`ifdef EX_MEM_BUBBLE_CNT_EN
   ,output logic [31:0]       bubble_cnt
`endif
);
   logic [ADDR_W-1:0]   r_mem_wd;
   logic                r_mem_wreg;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [2*DATA_W-1:0] r_hilo;
   logic [1:0]          r_cnt;
   logic                w_bubble;
   logic                w_hold;
   logic                w_unused;
   assign w_bubble = stall[EX_IDX] & ~stall[MEM_IDX];
   assign w_hold   = stall[EX_IDX] & stall[MEM_IDX];
   assign w_unused = ^stall;
   always_ff @(posedge clk or posedge rst) begin
      if (rst || flush) begin
         r_mem_wd    <= '0;
         r_mem_wreg  <= 1'b0;
         r_mem_wdata <= '0;
         r_hilo      <= '0;
         r_cnt       <= '0;
      end else if (w_bubble) begin
         r_mem_wd    <= '0;
         r_mem_wreg  <= 1'b0;
         r_mem_wdata <= '0;
         r_hilo      <= bus.hilo_i;
         r_cnt       <= bus.cnt_i;
      end else if (!w_hold) begin
         // Capture ends any multi-cycle sequence, so the scratch state is cleared.
         r_mem_wd    <= bus.ex_wd;
         r_mem_wreg  <= bus.ex_wreg;
         r_mem_wdata <= bus.ex_wdata;
         r_hilo      <= '0;
         r_cnt       <= '0;
      end
   end
   assign bus.mem_wd    = r_mem_wd;
   assign bus.mem_wreg  = r_mem_wreg;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.hilo_o    = r_hilo;
   assign bus.cnt_o     = r_cnt;
`ifdef EX_MEM_BUBBLE_CNT_EN
   logic [31:0] r_bubble_cnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst || flush) r_bubble_cnt <= '0;
      else if (w_bubble) r_bubble_cnt <= r_bubble_cnt + 32'd1;
   end
   assign bubble_cnt = r_bubble_cnt;
`endif
endmodule
